// File: rtl/usb_phy_pkg.sv
// Shared types and constants for the USB receive packet path:
// FSM states, error codes, SYNC pattern and size defaults.
package usb_phy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_EOP,
    ST_ERR
  } rx_state_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_STUFF   = 3'd1,
    ERR_ALIGN   = 3'd2,
    ERR_BABBLE  = 3'd3,
    ERR_TIMEOUT = 3'd4
  } rx_err_e;

  // Arrival order 0,0,0,0,0,0,0,1 with newest bit in the LSB.
  localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

  localparam int MAX_BYTES_DEF   = 1027;
  localparam int BIT_TIMEOUT_DEF = 16;
  localparam int CNT_W           = 11;

endpackage

// File: rtl/usb_rx_pkt_ctrl_if.sv
// Packet-side output bundle of the receive controller.
// master: controller drives; slave: packet consumer observes.
interface usb_rx_pkt_ctrl_if;
  import usb_phy_pkg::*;

  logic [7:0]       o_byte;
  logic             o_byte_valid;
  logic             o_pkt_start;
  logic             o_pkt_end;
  logic             o_pkt_err;
  logic [2:0]       o_err_code;
  logic             o_active;
  logic [CNT_W-1:0] o_byte_count;

  modport master (
    output o_byte, o_byte_valid,
    output o_pkt_start, o_pkt_end, o_pkt_err,
    output o_err_code, o_active, o_byte_count
  );

  modport slave (
    input o_byte, o_byte_valid,
    input o_pkt_start, o_pkt_end, o_pkt_err,
    input o_err_code, o_active, o_byte_count
  );

endinterface

// File: rtl/rx_byte_assembler.sv
// Packs destuffed bits (LSB first) into bytes and counts bytes.
// Ports: clr_i restarts a packet, bit_i/bit_valid_i feed bits;
// byte_o/byte_valid_o/byte_count_o are registered; *_nxt_o are
// the next-state values for end-of-packet alignment checks.
module rx_byte_assembler
  import usb_phy_pkg::*;
#(
  parameter int CW = CNT_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          bit_i,
  input  logic          bit_valid_i,
  output logic [7:0]    byte_o,
  output logic          byte_valid_o,
  output logic [CW-1:0] byte_count_o,
  output logic [2:0]    bit_cnt_nxt_o,
  output logic [CW-1:0] byte_count_nxt_o
);

  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic          vld_q, vld_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    byte_d    = byte_q;
    vld_d     = 1'b0;
    cnt_d     = cnt_q;
    if (clr_i) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
      cnt_d     = '0;
    end else if (bit_valid_i) begin
      shreg_d[bit_cnt_q] = bit_i;
      if (bit_cnt_q == 3'd7) begin
        byte_d    = shreg_d;
        vld_d     = 1'b1;
        bit_cnt_d = '0;
        cnt_d     = cnt_q + 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      byte_q    <= '0;
      vld_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign byte_o           = byte_q;
  assign byte_valid_o     = vld_q;
  assign byte_count_o     = cnt_q;
  assign bit_cnt_nxt_o    = bit_cnt_d;
  assign byte_count_nxt_o = cnt_d;

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: SYNC detect, destuffer feed,
// packet FSM with stuff/align/babble/timeout errors.
// Ports: i_clk/i_rst, line bits i_bit/i_bit_valid/i_se0,
// destuffer link o_dstf_*/i_dstf_*, packet bundle pkt (master).
module usb_rx_pkt_ctrl
  import usb_phy_pkg::*;
#(
  parameter int MAX_BYTES   = MAX_BYTES_DEF,
  parameter int BIT_TIMEOUT = BIT_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bit,
  input  logic i_bit_valid,
  input  logic i_se0,
  output logic o_dstf_packet_start,
  output logic o_dstf_data,
  output logic o_dstf_valid,
  input  logic i_dstf_data,
  input  logic i_dstf_valid,
  input  logic i_dstf_error,
  usb_rx_pkt_ctrl_if.master pkt
);

  localparam int TO_W = $clog2(BIT_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(BIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  rx_state_e        state_q;
  rx_err_e          err_code_q;
  logic [6:0]       hist_q;
  logic [6:0]       hist_vld_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             dstf_start_q;
  logic             pkt_start_q;
  logic             pkt_end_q;
  logic             pkt_err_q;

  logic             bit_ok;
  logic             se0_ok;
  logic [7:0]       hist_nxt;
  logic             sync_hit;
  logic             in_pkt;
  logic             stuff_err;
  logic             babble;
  logic             timeout;
  logic             acc;
  logic             eop_ok;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] byte_cnt_nxt;
  logic [2:0]       bit_cnt_nxt;

  assign bit_ok   = i_bit_valid & ~i_se0;
  assign se0_ok   = i_bit_valid & i_se0;
  assign hist_nxt = {hist_q, i_bit};
  assign in_pkt   = (state_q == ST_DATA) |
                    (state_q == ST_EOP);

  // hist_vld_q tracks how many bits arrived since the last clear,
  // so a cleared history cannot alias the SYNC pattern.
  assign sync_hit = (state_q == ST_IDLE) & bit_ok &
                    (&hist_vld_q) &
                    (hist_nxt == SYNC_PATTERN);

  // The destuffer still shows the previous packet's sticky error
  // in the cycle it first sees packet_start.
  assign stuff_err = in_pkt & i_dstf_error & ~dstf_start_q;
  assign babble    = in_pkt & i_dstf_valid &
                     (byte_cnt == MAX_CNT);
  assign timeout   = (state_q == ST_DATA) & ~i_bit_valid &
                     (to_cnt_q == TO_LAST);
  assign acc       = in_pkt & i_dstf_valid &
                     ~stuff_err & ~babble;
  assign eop_ok    = (bit_cnt_nxt == 3'd0) &
                     (byte_cnt_nxt != '0);

  assign o_dstf_packet_start = dstf_start_q;
  assign o_dstf_data         = i_bit;
  assign o_dstf_valid        = (state_q == ST_DATA) & bit_ok;

  rx_byte_assembler #(
    .CW (CNT_W)
  ) u_asm (
    .clk_i            (i_clk),
    .rst_i            (i_rst),
    .clr_i            (sync_hit),
    .bit_i            (i_dstf_data),
    .bit_valid_i      (acc),
    .byte_o           (pkt.o_byte),
    .byte_valid_o     (pkt.o_byte_valid),
    .byte_count_o     (byte_cnt),
    .bit_cnt_nxt_o    (bit_cnt_nxt),
    .byte_count_nxt_o (byte_cnt_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      err_code_q   <= ERR_NONE;
      hist_q       <= '0;
      hist_vld_q   <= '0;
      to_cnt_q     <= '0;
      dstf_start_q <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      dstf_start_q <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          to_cnt_q <= '0;
          if (se0_ok) begin
            hist_q     <= '0;
            hist_vld_q <= '0;
          end else if (bit_ok) begin
            hist_q     <= hist_nxt[6:0];
            hist_vld_q <= {hist_vld_q[5:0], 1'b1};
            if (sync_hit) begin
              state_q      <= ST_DATA;
              err_code_q   <= ERR_NONE;
              hist_vld_q   <= '0;
              dstf_start_q <= 1'b1;
              pkt_start_q  <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          to_cnt_q <= i_bit_valid ? '0 : to_cnt_q + 1'b1;
          if (stuff_err) begin
            state_q    <= ST_ERR;
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_STUFF;
          end else if (babble) begin
            state_q    <= ST_ERR;
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_BABBLE;
          end else if (timeout) begin
            state_q    <= ST_ERR;
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end else if (se0_ok) begin
            state_q <= ST_EOP;
          end
        end
        ST_EOP: begin
          to_cnt_q <= '0;
          state_q  <= ST_IDLE;
          if (stuff_err) begin
            state_q    <= ST_ERR;
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_STUFF;
          end else if (babble) begin
            state_q    <= ST_ERR;
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_BABBLE;
          end else if (eop_ok) begin
            pkt_end_q <= 1'b1;
          end else begin
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_ALIGN;
          end
        end
        ST_ERR: begin
          to_cnt_q <= '0;
          if (se0_ok) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pkt.o_pkt_start  = pkt_start_q;
  assign pkt.o_pkt_end    = pkt_end_q;
  assign pkt.o_pkt_err    = pkt_err_q;
  assign pkt.o_err_code   = err_code_q;
  assign pkt.o_active     = in_pkt;
  assign pkt.o_byte_count = byte_cnt;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for usb_rx_pkt_ctrl with a behavioural
// bit destuffer; expected bytes and codes are hand-derived.
module tb_usb_rx_pkt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, bit_in, bit_vld, se0;
  logic dstf_start, dstf_data, dstf_vld;
  logic ds_data = 1'b0;
  logic ds_vld  = 1'b0;
  logic ds_err  = 1'b0;
  int   ds_ones = 0;

  usb_rx_pkt_ctrl_if pkt();

  usb_rx_pkt_ctrl #(
    .MAX_BYTES   (4),
    .BIT_TIMEOUT (16)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_bit               (bit_in),
    .i_bit_valid         (bit_vld),
    .i_se0               (se0),
    .o_dstf_packet_start (dstf_start),
    .o_dstf_data         (dstf_data),
    .o_dstf_valid        (dstf_vld),
    .i_dstf_data         (ds_data),
    .i_dstf_valid        (ds_vld),
    .i_dstf_error        (ds_err),
    .pkt                 (pkt)
  );

  // Destuffer: after six 1s the next bit is a stuff bit; 0 is
  // dropped, 1 raises a sticky error. One cycle of latency.
  always @(posedge clk) begin
    int   n;
    logic e;
    n = ds_ones;
    e = ds_err;
    if (rst || dstf_start) begin
      n = 0;
      e = 1'b0;
    end
    ds_vld <= 1'b0;
    if (!rst && dstf_vld) begin
      if (n == 6) begin
        if (dstf_data) e = 1'b1;
        n = 0;
      end else begin
        ds_vld  <= 1'b1;
        ds_data <= dstf_data;
        n = dstf_data ? n + 1 : 0;
      end
    end
    ds_ones <= n;
    ds_err  <= e;
  end

  logic [7:0] got_q[$];
  int n_start = 0;
  int n_end   = 0;
  int n_err   = 0;
  logic [2:0] last_code = 3'd0;

  always @(negedge clk) begin
    if (pkt.o_byte_valid === 1'b1) got_q.push_back(pkt.o_byte);
    if (pkt.o_pkt_start === 1'b1) n_start++;
    if (pkt.o_pkt_end === 1'b1) n_end++;
    if (pkt.o_pkt_err === 1'b1) begin
      n_err++;
      last_code = pkt.o_err_code;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int b_start, b_end, b_err, b_bytes;
  int tx_ones;
  logic [7:0] exp_q[$];

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, act, exp);
    end
  endtask

  task automatic mark();
    b_start = n_start;
    b_end   = n_end;
    b_err   = n_err;
    b_bytes = got_q.size();
  endtask

  task automatic drv(input logic b, input logic v,
                     input logic s);
    @(negedge clk);
    bit_in  = b;
    bit_vld = v;
    se0     = s;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    drv(b, 1'b1, 1'b0);
    if (b) begin
      tx_ones++;
      if (tx_ones == 6) begin
        drv(1'b0, 1'b1, 1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) drv(1'b0, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    tx_ones = 0;
  endtask

  task automatic send_se0();
    drv(1'b0, 1'b1, 1'b1);
    drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_pkt(input string tag, input int ns,
                           input int ne, input int nerr,
                           input int code, input int cnt);
    idle(6);
    #1;
    check({tag, ".start"}, n_start - b_start, ns);
    check({tag, ".end"}, n_end - b_end, ne);
    check({tag, ".err"}, n_err - b_err, nerr);
    check({tag, ".code"}, 32'(pkt.o_err_code), code);
    if (nerr != 0)
      check({tag, ".pulse_code"}, 32'(last_code), code);
    check({tag, ".count"}, 32'(pkt.o_byte_count), cnt);
    check({tag, ".active"}, 32'(pkt.o_active), 0);
    check({tag, ".nbytes"}, got_q.size() - b_bytes,
          exp_q.size());
    foreach (exp_q[i])
      if (b_bytes + i < got_q.size())
        check($sformatf("%s.byte%0d", tag, i),
              32'(got_q[b_bytes + i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst     = 1'b1;
    bit_in  = 1'b0;
    bit_vld = 1'b0;
    se0     = 1'b0;
    tx_ones = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.active", 32'(pkt.o_active), 0);
    check("rst.count", 32'(pkt.o_byte_count), 0);
    check("rst.code", 32'(pkt.o_err_code), 0);
    check("rst.byte", 32'(pkt.o_byte), 0);
    check("rst.pulses", 32'({pkt.o_pkt_start, pkt.o_pkt_end,
          pkt.o_pkt_err, pkt.o_byte_valid, dstf_start}), 0);
    check("rst.dstf_vld", 32'(dstf_vld), 0);
    @(negedge clk);
    rst = 1'b0;

    mark();
    send_sync();
    send_byte(8'hC3);
    check("s1.active", 32'(pkt.o_active), 1);
    send_byte(8'hA5);
    send_se0();
    exp_q = {8'hC3, 8'hA5};
    check_pkt("s1", 1, 1, 0, 0, 2);

    mark();
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h7E);
    send_se0();
    exp_q = {8'hFF, 8'h7E};
    check_pkt("s2", 1, 1, 0, 0, 2);

    mark();
    send_sync();
    repeat (7) drv(1'b1, 1'b1, 1'b0);
    send_byte(8'h12);
    exp_q.delete();
    check_pkt("s3", 1, 0, 1, 1, 0);
    send_se0();

    mark();
    send_sync();
    send_byte(8'h5A);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_se0();
    exp_q = {8'h5A};
    check_pkt("s4", 1, 0, 1, 2, 1);

    mark();
    send_sync();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
    check_pkt("s5", 1, 0, 1, 3, 4);
    send_sync();
    idle(4);
    check("s5.err_ignores_sync", n_start - b_start, 1);
    check("s5.err_active", 32'(pkt.o_active), 0);
    send_se0();

    mark();
    send_sync();
    send_byte(8'h81);
    idle(15);
    send_byte(8'h42);
    send_se0();
    exp_q = {8'h81, 8'h42};
    check_pkt("s6", 1, 1, 0, 0, 2);

    mark();
    send_sync();
    send_byte(8'h3C);
    idle(15);
    check("s7.no_timeout_yet", n_err - b_err, 0);
    exp_q = {8'h3C};
    check_pkt("s7", 1, 0, 1, 4, 1);
    send_se0();

    mark();
    send_sync();
    send_byte(8'h99);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst     = 1'b1;
    bit_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    #1;
    check("s8.no_end", n_end - b_end, 0);
    check("s8.no_err", n_err - b_err, 0);
    check("s8.count", 32'(pkt.o_byte_count), 0);
    check("s8.active", 32'(pkt.o_active), 0);
    check("s8.nbytes", got_q.size() - b_bytes, 1);

    mark();
    send_sync();
    send_byte(8'hE7);
    send_se0();
    exp_q = {8'hE7};
    check_pkt("s8b", 1, 1, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_pkt_ctrl.md
USB_RX_PKT_CTRL -- requirements
Module: usb_rx_pkt_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 1027, max destuffed bytes per packet (PID+1024 data+CRC16).
REQ-002 SHALL have parameter BIT_TIMEOUT, default 16, max i_clk cycles between i_bit_valid strobes while a packet is open.
REQ-003 i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_bit, i_bit_valid  input  1,1  NRZI-decoded line bit and its strobe.
REQ-006 i_se0  input  1  line SE0, qualified by i_bit_valid.
REQ-007 o_dstf_packet_start, o_dstf_data, o_dstf_valid  output  1,1,1  drive the bit destuffer's packet_start, data and valid inputs.
REQ-008 i_dstf_data, i_dstf_valid, i_dstf_error  input  1,1,1  destuffer outputs (one-cycle latency, error sticky until packet_start).
REQ-009 o_byte  output  8  assembled byte, LSB first on the wire.
REQ-010 o_byte_valid, o_pkt_start, o_pkt_end, o_pkt_err  output  1 each  single-cycle pulses.
REQ-011 o_err_code  output  3  0 none, 1 stuff, 2 align, 3 babble, 4 timeout; valid with o_pkt_err.
REQ-012 o_active  output  1  high from SYNC detect until packet end or error.
REQ-013 o_byte_count  output  11  bytes delivered in current packet.

Function
REQ-014 SHALL implement states IDLE, DATA, EOP, ERR.
REQ-015 IDLE: shift valid bits into 8-bit history; history in arrival order 0,0,0,0,0,0,0,1 SHALL move to DATA and pulse o_dstf_packet_start and o_pkt_start in the cycle after the final SYNC bit.
REQ-016 IDLE: i_se0 SHALL clear the history; no output pulses.
REQ-017 DATA: each non-SE0 valid bit SHALL be forwarded to o_dstf_data/o_dstf_valid in the same cycle; o_dstf_valid SHALL be 0 in all other states.
REQ-018 DATA: each i_dstf_valid bit SHALL shift into byte register at position bit_cnt; on 8th bit o_byte_valid SHALL pulse next cycle, bit_cnt wraps to 0, o_byte_count increments.
REQ-019 i_dstf_valid with o_byte_count == MAX_BYTES SHALL enter ERR with code 3; no further o_byte_valid.
REQ-020 i_dstf_error high in DATA or EOP SHALL enter ERR with code 1 (priority: stuff > babble > timeout).
REQ-021 No i_bit_valid for BIT_TIMEOUT consecutive cycles in DATA SHALL enter ERR with code 4.
REQ-022 DATA: valid i_se0 SHALL enter EOP; EOP lasts exactly 1 cycle to absorb the pending destuffer output.
REQ-023 EOP exit: bit_cnt==0 and o_byte_count>=1 -> pulse o_pkt_end, go IDLE; otherwise pulse o_pkt_err with code 2, go IDLE.
REQ-024 Entering ERR SHALL pulse o_pkt_err once with its code; ERR SHALL ignore data and return to IDLE on next valid i_se0.
REQ-025 o_active SHALL be 1 in DATA and EOP, 0 in IDLE and ERR.
REQ-026 o_byte_count SHALL hold its final value until the next o_pkt_start, which zeroes it.
REQ-027 SYNC detect in same cycle as anything else is impossible (IDLE only); SE0 and i_dstf_valid in same DATA cycle SHALL still accept the byte bit before EOP.

Reset
REQ-028 i_rst SHALL force IDLE, clear history, bit_cnt, timeout counter, o_byte, o_byte_count, o_err_code, and all pulse/level outputs to 0 in the following cycle.
REQ-029 i_rst mid-packet SHALL produce no o_pkt_end or o_pkt_err; o_dstf_packet_start pulses at next SYNC.

Structure
REQ-030 Package usb_phy_pkg SHALL hold the state enum, error-code enum, SYNC pattern constant and MAX_BYTES default.
REQ-031 Byte assembly (bit_cnt, shift register, byte counter) SHALL be a sub-module rx_byte_assembler; FSM, SYNC detect and timeout live in top.

Verification
REQ-032 SYNC 00000001, bytes 0xC3 0xA5, SE0 -> o_pkt_start, o_byte 0xC3 then 0xA5, o_pkt_end, o_byte_count=2.
REQ-033 Byte 0xFF followed by stuffed 0 then 0x7E -> bytes 0xFF, 0x7E, stuffed bit absent; stuffed bit forced 1 -> o_pkt_err code 1.
REQ-034 SYNC, 1 byte + 3 bits, SE0 -> o_pkt_err code 2, o_byte_count=1, return to IDLE.
REQ-035 MAX_BYTES=4, send 5 bytes -> 4 o_byte_valid, o_pkt_err code 3, ERR until SE0.
REQ-036 SYNC, 1 byte, 16 idle cycles -> o_pkt_err code 4; i_rst during byte 2 of another packet -> no end/err pulse, next SYNC works.
